// File: rtl/mult_div_pkg.sv
// Shared encodings for the multicycle multiply/divide unit: operation codes and FSM states.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIN,
    ST_DZ
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_twos_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and the result sign fix-up.
module twos_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] x_i,
  input  logic         neg_i,
  output logic [N-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + 1'b1) : x_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide sharing one
// 2*WIDTH shift register, with registered HI/LO results and a divide-by-zero pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_e             state_q;
  logic               op_div_q;
  logic               sign_q_q;
  logic               sign_r_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = op_is_signed(op);

  twos_negate #(.N(WIDTH)) u_neg_a (.x_i(a), .neg_i(is_signed & a[WIDTH-1]), .y_o(mag_a));
  twos_negate #(.N(WIDTH)) u_neg_b (.x_i(b), .neg_i(is_signed & b[WIDTH-1]), .y_o(mag_b));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                              : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; the shifted remainder is WIDTH+1 bits so
  // the borrow of the trial subtract lands in the top bit.
  assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = rem_shift - {1'b0, opnd_q};
  assign div_acc_d = div_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  twos_negate #(.N(2*WIDTH)) u_fix_p (.x_i(acc_q), .neg_i(sign_q_q), .y_o(prod_fix));
  twos_negate #(.N(WIDTH)) u_fix_q (.x_i(acc_q[WIDTH-1:0]), .neg_i(sign_q_q), .y_o(quo_fix));
  twos_negate #(.N(WIDTH)) u_fix_r (.x_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sign_r_q),
                                    .y_o(rem_fix));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_div_q <= op[1];
            sign_q_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r_q <= is_signed & a[WIDTH-1];
            cnt_q    <= CNT_INIT;
            busy     <= 1'b1;
            if (!op[1]) begin
              state_q <= ST_MUL;
              acc_q   <= {{WIDTH{1'b0}}, mag_b};
              opnd_q  <= mag_a;
            end else begin
              state_q <= (b == '0) ? ST_DZ : ST_DIV;
              acc_q   <= {{WIDTH{1'b0}}, mag_a};
              opnd_q  <= mag_b;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= (state_q == ST_MUL) ? mul_acc_d : div_acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) state_q <= ST_FIN;
        end
        ST_FIN: begin
          if (op_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_DZ: begin
          div_zero <= 1'b1;
          busy     <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8: vector table plus corner sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, sel8;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic        busy_s, done_s, dz_s;
  logic [31:0] hi_s, lo_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start & ~sel8), .op(op), .a(a), .b(b),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start & sel8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign dz_s   = sel8 ? dz8 : dz32;
  assign hi_s   = sel8 ? {24'h0, hi8} : hi32;
  assign lo_s   = sel8 ? {24'h0, lo8} : lo32;

  typedef struct {
    logic        w8;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vt[17];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int cyc, output logic early, output logic moved);
    logic [31:0] h0, l0;
    h0 = hi_s; l0 = lo_s; cyc = 0; early = 1'b0; moved = 1'b0;
    while (busy_s && cyc < 200) begin
      if (done_s) early = 1'b1;
      if (hi_s !== h0 || lo_s !== l0) moved = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string nm, input logic w, input logic [1:0] o,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el);
    int   cyc;
    logic early, moved;
    sel8 = w;
    start_op(o, x, y);
    wait_done(cyc, early, moved);
    chk({nm, " busy_cycles"}, 64'(cyc), w ? 64'd9 : 64'd33);
    chk({nm, " done"}, 64'(done_s), 64'd1);
    chk({nm, " hi"}, 64'(hi_s), 64'(eh));
    chk({nm, " lo"}, 64'(lo_s), 64'(el));
    chk({nm, " early_done"}, 64'(early), 64'd0);
    chk({nm, " result_hold"}, 64'(moved), 64'd0);
    chk({nm, " div_zero"}, 64'(dz_s), 64'd0);
  endtask

  initial begin
    int   cyc;
    logic early, moved, seen;

    vt[0]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{1'b0, 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vt[2]  = '{1'b0, 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[3]  = '{1'b0, 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[4]  = '{1'b0, 2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vt[5]  = '{1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[6]  = '{1'b0, 2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vt[7]  = '{1'b0, 2'b00, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vt[8]  = '{1'b0, 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[9]  = '{1'b0, 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vt[10] = '{1'b0, 2'b11, 32'h00000005, 32'h80000000, 32'h00000005, 32'h00000000};
    vt[11] = '{1'b0, 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vt[12] = '{1'b1, 2'b01, 32'h000000FF, 32'h000000FF, 32'h000000FE, 32'h00000001};
    vt[13] = '{1'b1, 2'b00, 32'h000000FD, 32'h00000007, 32'h000000FF, 32'h000000EB};
    vt[14] = '{1'b1, 2'b10, 32'h00000080, 32'h000000FF, 32'h00000000, 32'h00000080};
    vt[15] = '{1'b1, 2'b10, 32'h000000F9, 32'h00000002, 32'h000000FF, 32'h000000FD};
    vt[16] = '{1'b1, 2'b11, 32'h000000C8, 32'h00000007, 32'h00000004, 32'h0000001C};

    reset = 1'b1; start = 1'b0; sel8 = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy32", 64'(busy32), 64'd0);
    chk("reset flags32", 64'({done32, dz32}), 64'd0);
    chk("reset hilo32", {hi32, lo32}, 64'd0);
    chk("reset busy8", 64'(busy8), 64'd0);
    chk("reset hilo8", 64'({hi8, lo8}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++)
      run_check($sformatf("vec%0d", i), vt[i].w8, vt[i].op, vt[i].a, vt[i].b,
                vt[i].hi, vt[i].lo);

    // Divide by zero leaves the preloaded results untouched.
    run_check("preload", 1'b0, 2'b01, 32'd3, 32'd5, 32'd0, 32'd15);
    start_op(2'b10, 32'd5, 32'd0);
    chk("dz busy_e0", 64'(busy_s), 64'd1);
    chk("dz flag_e0", 64'(dz_s), 64'd0);
    @(posedge clk); #1;
    chk("dz flag_e1", 64'(dz_s), 64'd1);
    chk("dz busy_e1", 64'(busy_s), 64'd0);
    chk("dz done_e1", 64'(done_s), 64'd0);
    @(posedge clk); #1;
    chk("dz flag_e2", 64'(dz_s), 64'd0);
    chk("dz done_e2", 64'(done_s), 64'd0);
    chk("dz hilo", {hi_s, lo_s}, {32'd0, 32'd15});

    // A start mid-operation is ignored.
    start_op(2'b01, 32'hFFFFFFFF, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, early, moved);
    chk("ignore busy_rest", 64'(cyc), 64'd22);
    chk("ignore done", 64'(done_s), 64'd1);
    chk("ignore hilo", {hi_s, lo_s}, {32'd1, 32'hFFFFFFFE});

    // Back-to-back start in the done cycle.
    start_op(2'b11, 32'd100, 32'd7);
    chk("b2b busy_e0", 64'(busy_s), 64'd1);
    wait_done(cyc, early, moved);
    chk("b2b busy_cycles", 64'(cyc), 64'd33);
    chk("b2b hilo", {hi_s, lo_s}, {32'd2, 32'd14});

    // Reset mid-operation aborts with cleared results and no done.
    start_op(2'b00, 32'd3, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    chk("abort busy_before", 64'(busy_s), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", 64'(busy_s), 64'd0);
    chk("abort hilo", {hi_s, lo_s}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_s || busy_s) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort no_done", 64'(seen), 64'd0);

    // Reset wins over a simultaneous start.
    op = 2'b01; a = 32'd6; b = 32'd6; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("rst_start busy", 64'(busy_s), 64'd0);
    @(posedge clk); #1;
    chk("rst_start busy_next", 64'(busy_s), 64'd0);

    // WIDTH=8 reset mid-operation after a nonzero result.
    run_check("w8 pre", 1'b1, 2'b01, 32'd9, 32'd9, 32'd0, 32'd81);
    start_op(2'b11, 32'd200, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("w8 abort busy", 64'(busy_s), 64'd0);
    chk("w8 abort hilo", {hi_s, lo_s}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done_s) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("w8 abort no_done", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
